// File: rtl/memresp_pkg.sv
// Shared types and default constants for the mem_responder block.
package memresp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } memresp_state_t;

  localparam int MEMRESP_DEPTH_DEFAULT = 64;
  localparam int MEMRESP_WAIT_DEFAULT  = 2;

endpackage

// File: rtl/memresp_storage.sv
// Word array for mem_responder: registered read port with error clear, byte-masked write port.
module memresp_storage
  import memresp_pkg::*;
#(
  parameter int  DEPTH = MEMRESP_DEPTH_DEFAULT,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          resetN,
  input  logic          we,
  input  logic          re,
  input  logic          clr,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  input  logic [3:0]    be,
  output logic [31:0]   rdata
);

  // Contents start at zero at power-up and are never touched by reset.
  logic [31:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clock) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= clr ? '0 : mem[idx];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with WAIT_CYCLES wait states and address checking.
// Optional byte-masked writes are enabled by defining MEM_RESPONDER_BYTE_MASK_EN.
module mem_responder
  import memresp_pkg::*;
#(
  parameter int DEPTH       = MEMRESP_DEPTH_DEFAULT,
  parameter int WAIT_CYCLES = MEMRESP_WAIT_DEFAULT
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWData,
`ifdef MEM_RESPONDER_BYTE_MASK_EN
  input  logic [3:0]  reqByteEn,
`endif
  output logic        respValid,
  output logic [31:0] respData,
  output logic        respErr
);

  localparam int AW = $clog2(DEPTH);

  memresp_state_t state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           enter_resp;

  logic           wr_q;
  logic [31:0]    addr_q, wdata_q;
  logic [3:0]     be_q, be_in;

  logic           cur_wr, cur_err;
  logic [31:0]    cur_addr, cur_wdata;
  logic [3:0]     cur_be;

`ifdef MEM_RESPONDER_BYTE_MASK_EN
  assign be_in = reqByteEn;
`else
  assign be_in = 4'hF;
`endif

  assign reqReady  = (state_q == IDLE);
  assign respValid = (state_q == RESPOND);

  // With zero wait states RESPOND is entered on the accept edge, before the latches load.
  assign cur_wr    = (state_q == IDLE) ? reqWrite : wr_q;
  assign cur_addr  = (state_q == IDLE) ? reqAddr  : addr_q;
  assign cur_wdata = (state_q == IDLE) ? reqWData : wdata_q;
  assign cur_be    = (state_q == IDLE) ? be_in    : be_q;
  assign cur_err   = (cur_addr[1:0] != 2'b00) || (cur_addr[31:AW+2] != '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (reqValid) begin
          if (WAIT_CYCLES == 0) begin
            state_d    = RESPOND;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESPOND;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      respErr <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      respErr <= enter_resp & cur_err;
    end
  end

  always_ff @(posedge clock) begin
    if (reqValid && reqReady) begin
      wr_q    <= reqWrite;
      addr_q  <= reqAddr;
      wdata_q <= reqWData;
      be_q    <= be_in;
    end
  end

  // Reads and rejected accesses load the read register; rejected ones clear it to zero.
  memresp_storage #(.DEPTH(DEPTH)) u_storage (
    .clock  (clock),
    .resetN (resetN),
    .we     (enter_resp & cur_wr & ~cur_err),
    .re     (enter_resp & (~cur_wr | cur_err)),
    .clr    (cur_err),
    .idx    (cur_addr[AW+1:2]),
    .wdata  (cur_wdata),
    .be     (cur_be),
    .rdata  (respData)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (default build and MEM_RESPONDER_BYTE_MASK_EN).
module tb_mem_responder;

  logic        clock;
  logic        resetN;
  logic        reqValid, reqWrite, reqReady, respValid, respErr;
  logic [31:0] reqAddr, reqWData, respData;
  logic [3:0]  reqByteEn;

  logic        reqValid_z, reqWrite_z, reqReady_z, respValid_z, respErr_z;
  logic [31:0] reqAddr_z, reqWData_z, respData_z;
  logic [3:0]  reqByteEn_z;

  int n_checks = 0;
  int n_errors = 0;

  mem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut (
    .clock     (clock),
    .resetN    (resetN),
    .reqValid  (reqValid),
    .reqReady  (reqReady),
    .reqWrite  (reqWrite),
    .reqAddr   (reqAddr),
    .reqWData  (reqWData),
`ifdef MEM_RESPONDER_BYTE_MASK_EN
    .reqByteEn (reqByteEn),
`endif
    .respValid (respValid),
    .respData  (respData),
    .respErr   (respErr)
  );

  mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut_z (
    .clock     (clock),
    .resetN    (resetN),
    .reqValid  (reqValid_z),
    .reqReady  (reqReady_z),
    .reqWrite  (reqWrite_z),
    .reqAddr   (reqAddr_z),
    .reqWData  (reqWData_z),
`ifdef MEM_RESPONDER_BYTE_MASK_EN
    .reqByteEn (reqByteEn_z),
`endif
    .respValid (respValid_z),
    .respData  (respData_z),
    .respErr   (respErr_z)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access on the WAIT_CYCLES=2 instance; inputs are scrambled after acceptance.
  task automatic access(input string tag, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic [31:0] exp_data, input bit chk_data, input bit exp_err);
    int   lat;
    bit   ready_seen;
    logic [31:0] rd;
    logic er;
    lat = -1; ready_seen = 1'b0; rd = '0; er = 1'b0;
    @(negedge clock);
    reqValid = 1'b1; reqWrite = wr; reqAddr = addr; reqWData = wd; reqByteEn = be;
    check({tag, "_ready_idle"}, {31'd0, reqReady}, 32'd1);
    @(posedge clock);
    #1;
    reqValid = 1'b0; reqWrite = ~wr; reqAddr = 32'h0000_0003;
    reqWData = 32'hFFFF_FFFF; reqByteEn = 4'hF;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (reqReady) ready_seen = 1'b1;
      if (respValid) begin
        lat = c; rd = respData; er = respErr;
        break;
      end
    end
    check({tag, "_latency"}, lat, 32'd3);
    check({tag, "_ready_busy"}, {31'd0, ready_seen}, 32'd0);
    check({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
    if (chk_data) check({tag, "_data"}, rd, exp_data);
    @(negedge clock);
    check({tag, "_pulse"}, {30'd0, respValid, respErr}, 32'd0);
    check({tag, "_hold"}, respData, rd);
  endtask

  // Back-to-back accesses on the WAIT_CYCLES=0 instance with reqValid held high.
  task automatic burst(input string tag, input bit wr);
    int   cyc[6];
    logic [31:0] dat[6];
    int   nresp, i, in_win;
    bit   acc, err_seen, dup;
    nresp = 0; i = 0; err_seen = 1'b0; dup = 1'b0; in_win = 0;
    for (int c = 0; c < 40 && nresp < 6; c++) begin
      @(negedge clock);
      if (respValid_z) begin
        cyc[nresp] = c; dat[nresp] = respData_z;
        if (respErr_z) err_seen = 1'b1;
        nresp++;
      end
      if (i < 6) begin
        reqValid_z = 1'b1; reqWrite_z = wr; reqAddr_z = 32'(4 * i);
        reqWData_z = 32'hA000_0000 + 32'(i); reqByteEn_z = 4'hF;
      end else begin
        reqValid_z = 1'b0;
      end
      acc = reqValid_z && reqReady_z;
      @(posedge clock);
      if (acc) i++;
    end
    reqValid_z = 1'b0;
    check({tag, "_count"}, nresp, 32'd6);
    check({tag, "_err"}, {31'd0, err_seen}, 32'd0);
    if (nresp == 6) begin
      for (int k = 1; k < 6; k++) check({tag, "_gap"}, cyc[k] - cyc[k-1], 32'd2);
      for (int k = 0; k < 6; k++) if (cyc[k] < cyc[0] + 6) in_win++;
      check({tag, "_in6"}, in_win, 32'd3);
      if (!wr) for (int k = 0; k < 6; k++) check({tag, "_data"}, dat[k], 32'hA000_0000 + 32'(k));
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (respValid_z) dup = 1'b1;
    end
    check({tag, "_nodup"}, {31'd0, dup}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    resetN = 1'b0;
    reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqWData = '0; reqByteEn = 4'hF;
    reqValid_z = 1'b0; reqWrite_z = 1'b0; reqAddr_z = '0; reqWData_z = '0; reqByteEn_z = 4'hF;
    repeat (3) @(negedge clock);
    check("rst_valid", {31'd0, respValid}, 32'd0);
    check("rst_err", {31'd0, respErr}, 32'd0);
    check("rst_data", respData, 32'd0);
    resetN = 1'b1;
    check("rst_ready", {31'd0, reqReady}, 32'd1);

    access("wr10", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0, 1'b0);
    access("rd10", 1'b0, 32'h10, 32'd0, 4'hF, 32'hDEAD_BEEF, 1'b1, 1'b0);
    access("rd12", 1'b0, 32'h12, 32'd0, 4'hF, 32'd0, 1'b1, 1'b1);
    access("rd100", 1'b0, 32'h100, 32'd0, 4'hF, 32'd0, 1'b1, 1'b1);
    access("wr11", 1'b1, 32'h11, 32'hCAFE_F00D, 4'hF, 32'd0, 1'b1, 1'b1);
    access("wr110", 1'b1, 32'h110, 32'hCAFE_F00D, 4'hF, 32'd0, 1'b1, 1'b1);
    access("rd10b", 1'b0, 32'h10, 32'd0, 4'hF, 32'hDEAD_BEEF, 1'b1, 1'b0);
    access("rd00", 1'b0, 32'h0, 32'd0, 4'hF, 32'd0, 1'b1, 1'b0);
    access("wrFC", 1'b1, 32'hFC, 32'hA5A5_0001, 4'hF, 32'd0, 1'b0, 1'b0);
    access("rdFC", 1'b0, 32'hFC, 32'd0, 4'hF, 32'hA5A5_0001, 1'b1, 1'b0);
`ifdef MEM_RESPONDER_BYTE_MASK_EN
    access("wrmask", 1'b1, 32'h10, 32'h1122_3344, 4'b0101, 32'd0, 1'b0, 1'b0);
    access("rdmask", 1'b0, 32'h10, 32'd0, 4'hF, 32'hDE22_BE44, 1'b1, 1'b0);
    access("wrnone", 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 32'd0, 1'b0, 1'b0);
    access("rdnone", 1'b0, 32'h10, 32'd0, 4'b0000, 32'hDE22_BE44, 1'b1, 1'b0);
`else
    access("wrfull", 1'b1, 32'h10, 32'h1122_3344, 4'b0101, 32'd0, 1'b0, 1'b0);
    access("rdfull", 1'b0, 32'h10, 32'd0, 4'hF, 32'h1122_3344, 1'b1, 1'b0);
`endif

    // Abandon a write by resetting during its wait states.
    seen = 1'b0;
    @(negedge clock);
    reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 32'h20; reqWData = 32'h1234_5678;
    @(posedge clock);
    #1 reqValid = 1'b0;
    @(negedge clock);
    resetN = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, respValid}, 32'd0);
    check("mid_rst_ready", {31'd0, reqReady}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      if (respValid) seen = 1'b1;
    end
    resetN = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (respValid) seen = 1'b1;
    end
    check("mid_rst_noresp", {31'd0, seen}, 32'd0);
    check("mid_rst_data", respData, 32'd0);
    access("rd20", 1'b0, 32'h20, 32'd0, 4'hF, 32'h0000_0000, 1'b1, 1'b0);

    burst("b2b_wr", 1'b1);
    burst("b2b_rd", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 64, is the number of 32-bit words stored; it is a power of two, 4..1024.
REQ-002 Parameter WAIT_CYCLES, default 2, is the wait states inserted per access; range 0..15.
REQ-003 clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 resetN  in  1  asynchronous, active-low reset.
REQ-005 reqValid  in  1  initiator presents a request.
REQ-006 reqReady  out  1  responder can accept a request this cycle.
REQ-007 reqWrite  in  1  1 = write, 0 = read.
REQ-008 reqAddr  in  32  byte address.
REQ-009 reqWData  in  32  write data.
REQ-010 reqByteEn  in  4  per-byte write mask, bit i -> bits 8i+7:8i; the port exists only with MEM_RESPONDER_BYTE_MASK_EN.
REQ-011 respValid  out  1  one-cycle pulse: the response is complete.
REQ-012 respData  out  32  read data, valid only while respValid=1.
REQ-013 respErr  out  1  the access was rejected; valid only while respValid=1.

Function
REQ-014 The FSM has exactly three states: IDLE, WAIT and RESPOND.
REQ-015 reqReady=1 only in IDLE; the request is accepted on the edge where reqValid and reqReady are both 1.
REQ-016 On acceptance, the responder latches reqWrite, reqAddr, reqWData and reqByteEn; later input changes have no effect on the accepted access.
REQ-017 Accept transitions:
- WAIT_CYCLES>0: IDLE->WAIT, with the counter loaded to WAIT_CYCLES-1.
- WAIT_CYCLES=0: IDLE->RESPOND.
REQ-018 WAIT decrements the counter each cycle and moves to RESPOND on the edge where the counter is 0; WAIT lasts exactly WAIT_CYCLES cycles.
REQ-019 On the edge entering RESPOND:
- Read: registers storage[index] into respData.
- Write: commits reqWData to storage[index].
REQ-020 respValid=1 for exactly the one RESPOND cycle; RESPOND->IDLE unconditionally; there is no response backpressure.
REQ-021 Latency: a request accepted at edge N has respValid high in cycle N+1+WAIT_CYCLES; sustained throughput is one access per WAIT_CYCLES+2 cycles.
REQ-022 index = latched reqAddr[log2(DEPTH)+1:2].
REQ-023 An access errors if reqAddr[1:0]!=0 or if any reqAddr bit above log2(DEPTH)+1 is 1.
REQ-024 On error: respErr=1, respData=0, storage is unchanged, and timing is identical to a normal access.
REQ-025 Reads return the stored value as of the RESPOND edge; a read following a write to the same index returns the new data.
REQ-026 respData holds its last value outside RESPOND; respErr=0 outside RESPOND.
REQ-027 reqValid asserted outside IDLE is ignored and not queued.

Reset
REQ-028 resetN low asynchronously forces: state IDLE, counter 0, reqReady=1 after release, respValid=0, respErr=0, respData=0.
REQ-029 Reset mid-access abandons the access: a write not yet at its RESPOND edge is never committed, and no response is issued.
REQ-030 Storage contents are not affected by reset; storage is zero-initialised at time 0 only.
REQ-031 The first request can be accepted on the first rising edge after resetN deasserts.

Configuration
REQ-032 With MEM_RESPONDER_BYTE_MASK_EN defined, a write updates only the bytes whose reqByteEn bit is 1; reqByteEn=0000 is a legal no-op write, and reads ignore the mask.
REQ-033 Without MEM_RESPONDER_BYTE_MASK_EN, the reqByteEn port is absent and every write updates all 32 bits.

Structure
REQ-034 Shared package memresp_pkg holds:
- typedef memresp_state_t (IDLE, WAIT, RESPOND);
- constants MEMRESP_DEPTH_DEFAULT=64 and MEMRESP_WAIT_DEFAULT=2.
REQ-035 One sub-module, memresp_storage, holds the word array with a registered read port and a masked write port.
REQ-036 The FSM, counter, address check and output registers live in mem_responder.

Verification
REQ-037 Reset, then write 0xDEADBEEF to address 0x10 with WAIT_CYCLES=2: accepted at edge N, respValid=1 only in cycle N+3, respErr=0, reqReady=0 in cycles N+1..N+3.
REQ-038 Read address 0x10 directly after REQ-037: respData=0xDEADBEEF, respErr=0.
REQ-039 Read address 0x12, then read address 0x100 with DEPTH=64: each gives respValid=1, respErr=1, respData=0, with storage unchanged.
REQ-040 With MEM_RESPONDER_BYTE_MASK_EN: write 0x11223344 with reqByteEn=0101 over 0xDEADBEEF at 0x10, then read 0x10 -> 0xDE22BE44.
REQ-041 Start a write of 0x12345678 to 0x20, pull resetN low during WAIT, release, then read 0x20: respData=0x00000000, and no respValid occurs before the read.
REQ-042 With WAIT_CYCLES=0, hold reqValid high for 6 back-to-back reads: responses come every 2 cycles, exactly 3 complete in 6 cycles, and no request is lost or duplicated.
